// File: rtl/cr_file.sv
// cr_file: parametrised condition-register file with a one-entry commit stage.
//
// Holds NFIELD fields of FW bits (CR width W = NFIELD*FW). Bit numbering is big-endian:
// CR bit 0 is the MSB of field 0 and lives at vector index W-1. The same convention
// applies to req_data, req_fxm and busy (index NFIELD-1 is field 0).
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   req_valid/ready  write request handshake (accepted when both high at an edge)
//   req_op         0 WBIT, 1 WFIELD, 2 WMASK, 3 LOGIC
//   req_bt         target bit (WBIT/LOGIC) or bit inside the target field (WFIELD)
//   req_ba/bb      LOGIC source bit addresses
//   req_lop        LOGIC function (AND OR XOR NAND NOR EQV ANDC ORC)
//   req_fxm        WMASK field select
//   req_data       write data aligned to CR bit positions
//   ckpt_save      capture the post-commit CR into the checkpoint
//   ckpt_restore   reload the CR from the checkpoint and flush the commit stage
//   cr             committed CR value
//   busy           fields targeted by the write held in the commit stage
module cr_file #(
  parameter int unsigned NFIELD = 8,
  parameter int unsigned FW     = 4,
  parameter int unsigned AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [AW-1:0]        req_bt,
  input  logic [AW-1:0]        req_ba,
  input  logic [AW-1:0]        req_bb,
  input  logic [2:0]           req_lop,
  input  logic [NFIELD-1:0]    req_fxm,
  input  logic [NFIELD*FW-1:0] req_data,
  input  logic                 ckpt_save,
  input  logic                 ckpt_restore,
  output logic [NFIELD*FW-1:0] cr,
  output logic [NFIELD-1:0]    busy
);

  localparam int unsigned W = NFIELD * FW;

  typedef enum logic [1:0] {
    OpWbit   = 2'd0,
    OpWfield = 2'd1,
    OpWmask  = 2'd2,
    OpLogic  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    LopAnd  = 3'd0,
    LopOr   = 3'd1,
    LopXor  = 3'd2,
    LopNand = 3'd3,
    LopNor  = 3'd4,
    LopEqv  = 3'd5,
    LopAndc = 3'd6,
    LopOrc  = 3'd7
  } lop_e;

  logic [W-1:0]      cr_q, cr_d;
  logic [W-1:0]      ckpt_q, ckpt_d;
  logic [W-1:0]      en_q, en_d;
  logic [W-1:0]      wd_q, wd_d;
  logic [NFIELD-1:0] busy_q, busy_d;

  // Addresses widened so out-of-range values simply fail every decode compare.
  logic [31:0] bt_w, ba_w, bb_w;
  assign bt_w = 32'(req_bt);
  assign ba_w = 32'(req_ba);
  assign bb_w = 32'(req_bb);

  logic [W-1:0]      bt_bit, ba_bit, bb_bit, fld_en, fxm_en;
  logic [W-1:0]      new_en, new_wd, cr_commit;
  logic [NFIELD-1:0] ba_fld, bb_fld, new_busy;
  logic              a_bit, b_bit, lop_res, is_logic, hazard, accept;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bt_bit[W-1-i] = (bt_w == i);
    assign ba_bit[W-1-i] = (ba_w == i);
    assign bb_bit[W-1-i] = (bb_w == i);
    assign fld_en[W-1-i] = ((bt_w / FW) == (i / FW));
    assign fxm_en[W-1-i] = req_fxm[NFIELD-1-i/FW];
  end

  for (genvar f = 0; f < NFIELD; f++) begin : g_fld
    assign ba_fld[NFIELD-1-f]   = ((ba_w / FW) == f);
    assign bb_fld[NFIELD-1-f]   = ((bb_w / FW) == f);
    assign new_busy[NFIELD-1-f] = |new_en[W-1-f*FW -: FW];
  end

  // Sources beyond the CR match no decode bit and therefore read as 0.
  assign a_bit = |(ba_bit & cr_q);
  assign b_bit = |(bb_bit & cr_q);

  always_comb begin
    lop_res = 1'b0;
    case (lop_e'(req_lop))
      LopAnd:  lop_res = a_bit & b_bit;
      LopOr:   lop_res = a_bit | b_bit;
      LopXor:  lop_res = a_bit ^ b_bit;
      LopNand: lop_res = ~(a_bit & b_bit);
      LopNor:  lop_res = ~(a_bit | b_bit);
      LopEqv:  lop_res = ~(a_bit ^ b_bit);
      LopAndc: lop_res = a_bit & ~b_bit;
      LopOrc:  lop_res = a_bit | ~b_bit;
      default: lop_res = 1'b0;
    endcase
  end

  assign is_logic = (op_e'(req_op) == OpLogic);

  always_comb begin
    new_en = '0;
    case (op_e'(req_op))
      OpWbit:   new_en = bt_bit;
      OpWfield: new_en = fld_en;
      OpWmask:  new_en = fxm_en;
      OpLogic:  new_en = bt_bit;
      default:  new_en = '0;
    endcase
    new_wd = is_logic ? ({W{lop_res}} & new_en) : (req_data & new_en);
  end

  // A LOGIC read of a field still sitting in the commit stage would see stale data.
  assign hazard    = is_logic & (|((ba_fld | bb_fld) & busy_q));
  assign req_ready = ~rst & ~ckpt_restore & ~hazard;
  assign accept    = req_valid & req_ready;

  assign cr_commit = (cr_q & ~en_q) | (wd_q & en_q);

  always_comb begin
    cr_d   = cr_commit;
    ckpt_d = ckpt_q;
    en_d   = '0;
    wd_d   = '0;
    busy_d = '0;
    if (ckpt_restore) begin
      // Restore beats save and drops whatever is pending.
      cr_d = ckpt_q;
    end else begin
      if (ckpt_save) begin
        ckpt_d = cr_commit;
      end
      if (accept) begin
        en_d   = new_en;
        wd_d   = new_wd;
        busy_d = new_busy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_q   <= '0;
      ckpt_q <= '0;
      en_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      cr_q   <= cr_d;
      ckpt_q <= ckpt_d;
      en_q   <= en_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign cr   = cr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cr_file.sv
// tb_cr_file: scoreboard bench for cr_file. Each issued write pushes its expected busy
// and post-commit CR; a monitor pops an entry when the DUT accepts a request and checks
// busy one edge later and cr the edge after that. A second instance with NFIELD = 6
// covers out-of-range addresses.
module tb_cr_file;

  localparam logic [1:0] OpWbit   = 2'd0;
  localparam logic [1:0] OpWfield = 2'd1;
  localparam logic [1:0] OpWmask  = 2'd2;
  localparam logic [1:0] OpLogic  = 2'd3;

  typedef struct packed {
    logic [31:0] cr;
    logic [7:0]  busy;
    logic        flushed;
    logic [15:0] id;
  } exp_t;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_bt, req_ba, req_bb;
  logic [2:0]  req_lop;
  logic [7:0]  req_fxm;
  logic [31:0] req_data;
  logic        ckpt_save, ckpt_restore;
  logic [31:0] cr;
  logic [7:0]  busy;

  logic        d6_valid, d6_ready;
  logic [1:0]  d6_op;
  logic [4:0]  d6_bt, d6_ba, d6_bb;
  logic [2:0]  d6_lop;
  logic [5:0]  d6_fxm;
  logic [23:0] d6_data;
  logic [23:0] d6_cr;
  logic [5:0]  d6_busy;

  int   n_checks = 0;
  int   n_err    = 0;
  int   txn_id   = 0;
  exp_t exp_q[$];
  exp_t s1, s2;
  bit   s1_v, s2_v;

  cr_file #(.NFIELD(8), .FW(4), .AW(5)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_bt       (req_bt),
    .req_ba       (req_ba),
    .req_bb       (req_bb),
    .req_lop      (req_lop),
    .req_fxm      (req_fxm),
    .req_data     (req_data),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .cr           (cr),
    .busy         (busy)
  );

  cr_file #(.NFIELD(6), .FW(4), .AW(5)) u_dut6 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (d6_valid),
    .req_ready    (d6_ready),
    .req_op       (d6_op),
    .req_bt       (d6_bt),
    .req_ba       (d6_ba),
    .req_bb       (d6_bb),
    .req_lop      (d6_lop),
    .req_fxm      (d6_fxm),
    .req_data     (d6_data),
    .ckpt_save    (1'b0),
    .ckpt_restore (1'b0),
    .cr           (d6_cr),
    .busy         (d6_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: runs 2 time units after each falling edge, when inputs and outputs are stable.
  initial begin
    s1_v = 1'b0;
    s2_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (s2_v) begin
        if (!s2.flushed) check($sformatf("cr#%0d", s2.id), cr, s2.cr);
        s2_v = 1'b0;
      end
      if (s1_v) begin
        check($sformatf("busy#%0d", s1.id), 32'(busy), 32'(s1.busy));
        s2   = s1;
        s2_v = 1'b1;
        s1_v = 1'b0;
      end
      if (req_valid && req_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_accept: got accept, expected no request pending");
        end else begin
          s1   = exp_q.pop_front();
          s1_v = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [4:0] bt, input logic [4:0] ba,
                       input logic [4:0] bb, input logic [2:0] lop, input logic [7:0] fxm,
                       input logic [31:0] data, input logic [31:0] exp_cr,
                       input logic [7:0] exp_busy, input bit flushed, input int exp_stall);
    exp_t e;
    exp_t dropped;
    int   stall;
    stall     = 0;
    e.cr      = exp_cr;
    e.busy    = exp_busy;
    e.flushed = flushed;
    e.id      = 16'(txn_id);
    txn_id++;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_bt    = bt;
    req_ba    = ba;
    req_bb    = bb;
    req_lop   = lop;
    req_fxm   = fxm;
    req_data  = data;
    exp_q.push_back(e);
    #1;
    while (!req_ready && stall < 4) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (!req_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept#%0d: req_ready still 0, expected 1 within 4 cycles", e.id);
      dropped   = exp_q.pop_back();
      req_valid = 1'b0;
    end else begin
      check($sformatf("stall#%0d", e.id), 32'(stall), 32'(exp_stall));
    end
  endtask

  task automatic wr(input logic [1:0] op, input logic [4:0] bt, input logic [7:0] fxm,
                    input logic [31:0] data, input logic [31:0] exp_cr,
                    input logic [7:0] exp_busy, input bit flushed);
    issue(op, bt, 5'd0, 5'd0, 3'd0, fxm, data, exp_cr, exp_busy, flushed, 0);
  endtask

  task automatic lg(input logic [4:0] bt, input logic [4:0] ba, input logic [4:0] bb,
                    input logic [2:0] lop, input logic [31:0] exp_cr,
                    input logic [7:0] exp_busy, input int exp_stall);
    issue(OpLogic, bt, ba, bb, lop, 8'h00, 32'h0, exp_cr, exp_busy, 1'b0, exp_stall);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic save_pulse();
    @(negedge clk);
    req_valid = 1'b0;
    ckpt_save = 1'b1;
    @(negedge clk);
    ckpt_save = 1'b0;
  endtask

  // Restore edge falls between the two falling edges; optionally offers a request then.
  task automatic restore_pulse(input bit with_save, input bit with_req);
    @(negedge clk);
    req_valid    = with_req;
    req_op       = OpWbit;
    req_bt       = 5'd0;
    req_data     = 32'hFFFF_FFFF;
    ckpt_restore = 1'b1;
    ckpt_save    = with_save;
    #1;
    if (with_req) check("ready_in_restore", 32'(req_ready), 32'd0);
    @(negedge clk);
    ckpt_restore = 1'b0;
    ckpt_save    = 1'b0;
    req_valid    = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_op = OpWbit; req_bt = '0; req_ba = '0; req_bb = '0;
    req_lop = '0; req_fxm = '0; req_data = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    d6_valid = 1'b0; d6_op = '0; d6_bt = '0; d6_ba = '0; d6_bb = '0;
    d6_lop = '0; d6_fxm = '0; d6_data = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_cr", cr, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Field, mask and bit writes; consecutive requests go back to back.
    wr(OpWfield, 5'd8, 8'h00, 32'h00A0_0000, 32'h00A0_0000, 8'b0010_0000, 1'b0);
    wr(OpWmask,  5'd0, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF,        1'b0);
    wr(OpWmask,  5'd0, 8'h81, 32'h1234_5678, 32'h1FFF_FFF8, 8'b1000_0001, 1'b0);
    wr(OpWfield, 5'd4, 8'h00, 32'h0300_0000, 32'h13FF_FFF8, 8'b0100_0000, 1'b0);
    wr(OpWfield, 5'd7, 8'h00, 32'h0500_0000, 32'h15FF_FFF8, 8'b0100_0000, 1'b0);
    wr(OpWbit,   5'd2, 8'h00, 32'h2000_0000, 32'h35FF_FFF8, 8'b1000_0000, 1'b0);
    wr(OpWbit,   5'd9, 8'h00, 32'hFFBF_FFFF, 32'h35BF_FFF8, 8'b0010_0000, 1'b0);
    wr(OpWmask,  5'd0, 8'hFF, 32'h0000_0000, 32'h0000_0000, 8'hFF,        1'b0);

    // Hazard: LOGIC reading a busy field waits one cycle.
    wr(OpWbit, 5'd0, 8'h00, 32'h8000_0000, 32'h8000_0000, 8'b1000_0000, 1'b0);
    lg(5'd5,  5'd0, 5'd1,  3'd1, 32'h8400_0000, 8'b0100_0000, 1);  // OR
    lg(5'd2,  5'd0, 5'd1,  3'd6, 32'hA400_0000, 8'b1000_0000, 0);  // ANDC
    lg(5'd0,  5'd0, 5'd5,  3'd3, 32'h2400_0000, 8'b1000_0000, 1);  // NAND
    lg(5'd31, 5'd1, 5'd3,  3'd5, 32'h2400_0001, 8'b0000_0001, 1);  // EQV
    lg(5'd30, 5'd2, 5'd31, 3'd7, 32'h2400_0003, 8'b0000_0001, 1);  // ORC
    lg(5'd6,  5'd8, 5'd9,  3'd4, 32'h2600_0003, 8'b0100_0000, 0);  // NOR
    lg(5'd2,  5'd0, 5'd6,  3'd0, 32'h0600_0003, 8'b1000_0000, 1);  // AND
    lg(5'd7,  5'd6, 5'd8,  3'd2, 32'h0700_0003, 8'b0100_0000, 0);  // XOR

    // Checkpoint: restore discards the pending field 1 write.
    wr(OpWmask, 5'd0, 8'hFF, 32'hF000_0000, 32'hF000_0000, 8'hFF, 1'b0);
    save_pulse();
    wr(OpWfield, 5'd4, 8'h00, 32'h0F00_0000, 32'hF000_0000, 8'b0100_0000, 1'b1);
    restore_pulse(1'b0, 1'b1);
    check("restore_cr", cr, 32'hF000_0000);
    check("restore_busy", 32'(busy), 32'h0);

    // Save on the commit edge captures the committed value.
    wr(OpWfield, 5'd28, 8'h00, 32'h0000_0005, 32'hF000_0005, 8'b0000_0001, 1'b0);
    save_pulse();
    wr(OpWmask, 5'd0, 8'hFF, 32'h0000_0000, 32'h0000_0000, 8'hFF, 1'b0);
    idle(1);
    restore_pulse(1'b0, 1'b0);
    check("restore_saved_commit", cr, 32'hF000_0005);

    // Save together with restore: restore wins, checkpoint untouched.
    wr(OpWmask, 5'd0, 8'hFF, 32'h1111_1111, 32'h1111_1111, 8'hFF, 1'b0);
    idle(1);
    restore_pulse(1'b1, 1'b0);
    check("restore_wins", cr, 32'hF000_0005);
    wr(OpWmask, 5'd0, 8'hFF, 32'h2222_2222, 32'h2222_2222, 8'hFF, 1'b0);
    idle(1);
    restore_pulse(1'b0, 1'b0);
    check("ckpt_kept", cr, 32'hF000_0005);

    // Reset while a write is pending.
    wr(OpWfield, 5'd0, 8'h00, 32'hA000_0000, 32'hA000_0005, 8'b1000_0000, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    check("async_reset_cr", cr, 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
    check("async_reset_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rerelease", 32'(req_ready), 32'd1);
    idle(3);
    #1;
    check("dropped_write", cr, 32'h0);
    wr(OpWbit, 5'd31, 8'h00, 32'h0000_0001, 32'h0000_0001, 8'b0000_0001, 1'b0);
    idle(2);

    // Out-of-range addresses on the 6-field instance (W = 24).
    @(negedge clk);
    d6_valid = 1'b1; d6_op = OpWfield; d6_bt = 5'd20; d6_data = 24'h00000F;
    #1;
    check("d6_ready_wfield", 32'(d6_ready), 32'd1);
    @(negedge clk);
    d6_op = OpWbit; d6_bt = 5'd30; d6_data = 24'hFFFFFF;
    #1;
    check("d6_ready_oob_bit", 32'(d6_ready), 32'd1);
    check("d6_busy_wfield", 32'(d6_busy), 32'h01);
    @(negedge clk);
    d6_op = OpWfield; d6_bt = 5'd26; d6_data = 24'hFFFFFF;
    #1;
    check("d6_ready_oob_field", 32'(d6_ready), 32'd1);
    check("d6_busy_oob_bit", 32'(d6_busy), 32'h0);
    check("d6_cr_wfield", 32'(d6_cr), 32'h00000F);
    @(negedge clk);
    d6_op = OpLogic; d6_bt = 5'd0; d6_ba = 5'd30; d6_bb = 5'd31; d6_lop = 3'd4;
    #1;
    check("d6_ready_oob_src", 32'(d6_ready), 32'd1);
    check("d6_busy_oob_field", 32'(d6_busy), 32'h0);
    check("d6_cr_unchanged", 32'(d6_cr), 32'h00000F);
    @(negedge clk);
    d6_valid = 1'b0;
    #1;
    check("d6_busy_logic", 32'(d6_busy), 32'h20);
    @(negedge clk);
    #1;
    check("d6_cr_logic", 32'(d6_cr), 32'h80000F);
    check("d6_busy_idle", 32'(d6_busy), 32'h0);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
